// File: rtl/mac_sequencer.sv
// Dot-product pass sequencer: issues paired BRAM reads and marks each product as it leaves the multiplier.
// Only the address outputs and the strobe pipeline are registered; rd_en_o is gated by pause_i in the same cycle.
module mac_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int RD_LAT  = 2,
  parameter int MUL_LAT = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic [ADDR_W-1:0] base_a_i,
  input  logic [ADDR_W-1:0] base_b_i,
  output logic [ADDR_W-1:0] addr_a_o,
  output logic [ADDR_W-1:0] addr_b_o,
  output logic              rd_en_o,
  output logic              acc_en_o,
  output logic              acc_clear_o,
  output logic              acc_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int                PIPE_LAT = RD_LAT + MUL_LAT;
  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;

  logic [PIPE_LAT-1:0] vld_q, vld_d;
  logic [PIPE_LAT-1:0] fst_q, fst_d;
  logic [PIPE_LAT-1:0] lst_q, lst_d;

  logic [ADDR_W:0] len_eff;
  logic            issue;
  logic            is_last;

  // Lengths beyond the BRAM depth are clamped to one full sweep.
  assign len_eff = (len_i > DEPTH) ? DEPTH : len_i;
  assign issue   = (state_q == S_ISSUE) && !pause_i;
  assign is_last = (cnt_q == last_q);

  always_comb begin
    vld_d    = '0;
    fst_d    = '0;
    lst_d    = '0;
    vld_d[0] = issue;
    fst_d[0] = issue && (cnt_q == '0);
    lst_d[0] = issue && is_last;
    for (int k = 1; k < PIPE_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
      fst_d[k] = fst_q[k-1];
      lst_d[k] = lst_q[k-1];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          cnt_d  = '0;
          last_d = len_eff[ADDR_W-1:0] - ONE;
          if (len_eff != '0) begin
            addr_a_d = base_a_i;
            addr_b_d = base_b_i;
            state_d  = S_ISSUE;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_ISSUE: begin
        // Addresses stay on the final element once it has been issued.
        if (issue) begin
          if (is_last) begin
            state_d = S_DRAIN;
          end else begin
            cnt_d    = cnt_q + ONE;
            addr_a_d = addr_a_q + ONE;
            addr_b_d = addr_b_q + ONE;
          end
        end
      end
      S_DRAIN: begin
        if (vld_d == '0) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      vld_q    <= '0;
      fst_q    <= '0;
      lst_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
      vld_q    <= vld_d;
      fst_q    <= fst_d;
      lst_q    <= lst_d;
    end
  end

  assign addr_a_o    = addr_a_q;
  assign addr_b_o    = addr_b_q;
  assign rd_en_o     = issue;
  assign acc_en_o    = vld_q[PIPE_LAT-1];
  assign acc_clear_o = fst_q[PIPE_LAT-1];
  assign acc_last_o  = lst_q[PIPE_LAT-1];
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_FIN);

endmodule
